bitxor_seq: RTL

- Program sequencer that sits directly upstream of the end-pointer register stage.
- Holds a small loadable program of 2-bit opcodes, each with a data bit.
- Steps through the program one entry per clock and drives the downstream `inst` and `ztonxor` inputs.
- `ztonxor` is the running XOR of the data bits from entry 0 through the current entry.

---
 rtl/bitxor_seq.sv | 108 ++++++++++
 1 files changed

// File: rtl/bitxor_seq.sv
// Program sequencer: steps through a small loadable {op, bit} program one entry per
// clock, issuing the opcode on inst and the running XOR of the data bits on ztonxor.
module bitxor_seq #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [1:0]        load_op,
    input  logic              load_bit,
    input  logic              start,
    output logic [1:0]        inst,
    output logic              ztonxor,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [1:0]        OP_HALT = 2'b01;
    localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(PROG_DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [1:0] op;
        logic       dat;
    } entry_t;

    entry_t            mem [PROG_DEPTH];
    state_t            state, state_nx;
    logic [ADDR_W-1:0] pc_nx;
    logic [1:0]        inst_nx;
    logic              acc, acc_nx;
    logic              wr;
    logic              last;
    entry_t            wr_entry, first_entry, cur_entry, next_entry;

    function automatic logic [1:0] fwd(input logic [1:0] op);
        return (op == OP_HALT) ? 2'b00 : op;
    endfunction

    assign wr       = load_en && (state != S_RUN);
    assign wr_entry = {load_op, load_bit};

    // Write-first on entry 0 so a same-edge load and start runs the new value.
    assign first_entry = (wr && load_addr == '0) ? wr_entry : mem[0];
    assign cur_entry   = mem[pc];
    assign next_entry  = mem[pc + 1'b1];
    assign last        = (cur_entry.op == OP_HALT) || (pc == PC_LAST);

    // Program storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr) mem[load_addr] <= wr_entry;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            pc    <= '0;
            acc   <= 1'b0;
            inst  <= 2'b00;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            acc   <= acc_nx;
            inst  <= inst_nx;
        end
    end

    // acc already holds the prefix XOR through the entry at pc, so it drives ztonxor directly.
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        acc_nx   = acc;
        inst_nx  = 2'b00;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_nx = S_RUN;
                    pc_nx    = '0;
                    acc_nx   = first_entry.dat;
                    inst_nx  = fwd(first_entry.op);
                end
            end
            S_RUN: begin
                if (last) begin
                    state_nx = S_DONE;
                end else begin
                    pc_nx   = pc + 1'b1;
                    acc_nx  = acc ^ next_entry.dat;
                    inst_nx = fwd(next_entry.op);
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign ztonxor = acc;
    assign busy    = (state == S_RUN);
    assign done    = (state == S_DONE);

endmodule
